// File: rtl/cronometro_bcd.sv
// Purpose : mm:ss BCD stopwatch / countdown timer feeding the 4-digit display selector.
// Latency : digits step DIV cycles after RUN entry; fg/fin registered one edge after the causing input.
// Backpr. : none; buttons act immediately with priority rst > btn_clr > load > start/stop edge > tick.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   btn_ss              start/stop level; only its rising edge acts
//   btn_clr             clear to 00:00 / IDLE while high
//   dir                 0 = count up, 1 = count down (sampled at each tick)
//   load, pre_*         load saturated preset digits (IDLE or PAUSE only)
//   uns/des/unm/dem     registered BCD digits (ss units, ss tens, mm units, mm tens)
//   fg                  1 while counting (RUN)
//   fin                 one-cycle pulse when a countdown expires
module cronometro_bcd #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] pre_uns,
    input  logic [3:0] pre_des,
    input  logic [3:0] pre_unm,
    input  logic [3:0] pre_dem,
    output logic [3:0] uns,
    output logic [3:0] des,
    output logic [3:0] unm,
    output logic [3:0] dem,
    output logic       fg,
    output logic       fin
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    uns_q, uns_d, des_q, des_d, unm_q, unm_d, dem_q, dem_d;
    logic          fg_q, fg_d, fin_q, fin_d;
    logic          btn_ss_q, btn_ss_d;

    logic ss_edge, tick, load_ok, is_zero, is_one;

    assign ss_edge = btn_ss & ~btn_ss_q;
    assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign load_ok = load && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
    assign is_zero = (dem_q == 4'd0) && (unm_q == 4'd0) && (des_q == 4'd0) && (uns_q == 4'd0);
    assign is_one  = (dem_q == 4'd0) && (unm_q == 4'd0) && (des_q == 4'd0) && (uns_q == 4'd1);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        uns_d    = uns_q;
        des_d    = des_q;
        unm_d    = unm_q;
        dem_d    = dem_q;
        fin_d    = 1'b0;
        // Edge register always follows the button, so an edge swallowed by a
        // higher-priority action is not replayed on a later cycle.
        btn_ss_d = btn_ss;

        if (btn_clr) begin
            state_d = ST_IDLE;
            presc_d = '0;
            uns_d   = 4'd0;
            des_d   = 4'd0;
            unm_d   = 4'd0;
            dem_d   = 4'd0;
        end else if (load_ok) begin
            uns_d = (pre_uns > 4'd9) ? 4'd9 : pre_uns;
            des_d = (pre_des > 4'd5) ? 4'd5 : pre_des;
            unm_d = (pre_unm > 4'd9) ? 4'd9 : pre_unm;
            dem_d = (pre_dem > 4'd5) ? 4'd5 : pre_dem;
            if (state_q == ST_PAUSE) begin
                presc_d = '0;
            end
        end else if (ss_edge) begin
            case (state_q)
                ST_IDLE: begin
                    // A countdown from 00:00 has nothing to count; stay idle.
                    if (!(dir && is_zero)) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN:   state_d = ST_PAUSE;   // prescaler held: fraction kept
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;    // DONE ignores start/stop
            endcase
        end else if (state_q == ST_RUN) begin
            if (!tick) begin
                presc_d = presc_q + PW'(1);
            end else begin
                presc_d = '0;
                if (!dir) begin
                    if (uns_q != 4'd9) begin
                        uns_d = uns_q + 4'd1;
                    end else begin
                        uns_d = 4'd0;
                        if (des_q != 4'd5) begin
                            des_d = des_q + 4'd1;
                        end else begin
                            des_d = 4'd0;
                            if (unm_q != 4'd9) begin
                                unm_d = unm_q + 4'd1;
                            end else begin
                                unm_d = 4'd0;
                                dem_d = (dem_q != 4'd5) ? dem_q + 4'd1 : 4'd0;
                            end
                        end
                    end
                end else begin
                    // At 00:00 (dir flipped mid-run) the digits stay put.
                    if (!is_zero) begin
                        if (uns_q != 4'd0) begin
                            uns_d = uns_q - 4'd1;
                        end else begin
                            uns_d = 4'd9;
                            if (des_q != 4'd0) begin
                                des_d = des_q - 4'd1;
                            end else begin
                                des_d = 4'd5;
                                if (unm_q != 4'd0) begin
                                    unm_d = unm_q - 4'd1;
                                end else begin
                                    unm_d = 4'd9;
                                    dem_d = dem_q - 4'd1;
                                end
                            end
                        end
                    end
                    if (is_zero || is_one) begin
                        state_d = ST_DONE;
                        fin_d   = 1'b1;
                    end
                end
            end
        end

        fg_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            uns_q    <= 4'd0;
            des_q    <= 4'd0;
            unm_q    <= 4'd0;
            dem_q    <= 4'd0;
            fg_q     <= 1'b0;
            fin_q    <= 1'b0;
            // Resetting to 1 means a button held through reset does not start.
            btn_ss_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            uns_q    <= uns_d;
            des_q    <= des_d;
            unm_q    <= unm_d;
            dem_q    <= dem_d;
            fg_q     <= fg_d;
            fin_q    <= fin_d;
            btn_ss_q <= btn_ss_d;
        end
    end

    assign uns = uns_q;
    assign des = des_q;
    assign unm = unm_q;
    assign dem = dem_q;
    assign fg  = fg_q;
    assign fin = fin_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
module tb_cronometro_bcd;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pre_uns = 4'd0, pre_des = 4'd0, pre_unm = 4'd0, pre_dem = 4'd0;
    logic [3:0] uns, des, unm, dem;
    logic       fg, fin;

    cronometro_bcd #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .dir(dir), .load(load),
        .pre_uns(pre_uns), .pre_des(pre_des), .pre_unm(pre_unm), .pre_dem(pre_dem),
        .uns(uns), .des(des), .unm(unm), .dem(dem), .fg(fg), .fin(fin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int fin_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (fin === 1'b1) fin_cnt <= fin_cnt + 1;

    // Expected {dem,unm,des,uns} plus fg/fin, due after a given edge count.
    typedef struct {
        int          due;
        logic [15:0] d;
        logic        fg;
        logic        fin;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    function automatic void push_exp(int due, logic [15:0] d, logic efg, logic efin, string nm);
        exp_t x;
        x.due = due; x.d = d; x.fg = efg; x.fin = efin; x.nm = nm;
        sb.push_back(x);
    endfunction

    task automatic test_reset();
        int base;
        rst = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; load = 1'b0; dir = 1'b0;
        @(posedge clk); #1;
        base = cyc;
        push_exp(base + 1, 16'h0000, 1'b0, 1'b0, "reset_state");
        push_exp(base + 2, 16'h0000, 1'b0, 1'b0, "reset_release");
        for (int c = 1; c <= 2; c++) begin
            if (c == 2) rst = 1'b0;
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
        // One idle edge so the edge register sees the released button.
        @(posedge clk); #1;
    endtask

    task automatic test_start();
        int base = cyc;
        push_exp(base + 1,   16'h0000, 1'b1, 1'b0, "start_fg");
        push_exp(base + 10,  16'h0000, 1'b1, 1'b0, "start_before_tick");
        push_exp(base + 11,  16'h0001, 1'b1, 1'b0, "start_first_step");
        push_exp(base + 100, 16'h0009, 1'b1, 1'b0, "start_nine");
        push_exp(base + 101, 16'h0010, 1'b1, 1'b0, "start_ten");
        for (int c = 1; c <= 101; c++) begin
            if (c == 1) begin btn_ss = 1'b1; dir = 1'b0; end
            if (c == 2) btn_ss = 1'b0;
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int base = cyc;
        int fin0 = fin_cnt;
        push_exp(base + 1,  16'h0000, 1'b0, 1'b0, "wrap_clr");
        push_exp(base + 2,  16'h5958, 1'b0, 1'b0, "wrap_load");
        push_exp(base + 3,  16'h5958, 1'b1, 1'b0, "wrap_run");
        push_exp(base + 13, 16'h5959, 1'b1, 1'b0, "wrap_5959");
        push_exp(base + 23, 16'h0000, 1'b1, 1'b0, "wrap_0000");
        for (int c = 1; c <= 24; c++) begin
            case (c)
                1: btn_clr = 1'b1;
                2: begin btn_clr = 1'b0; load = 1'b1; pre_dem = 4'd5; pre_unm = 4'd9; pre_des = 4'd5; pre_uns = 4'd8; end
                3: begin load = 1'b0; btn_ss = 1'b1; end
                4: btn_ss = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
        n_tests++;
        if (fin_cnt - fin0 !== 0) begin
            n_fail++;
            $display("FAIL wrap_no_fin: got %0d fin cycles want 0", fin_cnt - fin0);
        end
    endtask

    task automatic test_countdown();
        int base = cyc;
        int fin0 = fin_cnt;
        push_exp(base + 12, 16'h0002, 1'b1, 1'b0, "down_before_tick");
        push_exp(base + 13, 16'h0001, 1'b1, 1'b0, "down_0001");
        push_exp(base + 22, 16'h0001, 1'b1, 1'b0, "down_hold_0001");
        push_exp(base + 23, 16'h0000, 1'b0, 1'b1, "down_expire");
        push_exp(base + 24, 16'h0000, 1'b0, 1'b0, "down_fin_drop");
        push_exp(base + 28, 16'h0000, 1'b0, 1'b0, "done_ignores_ss");
        push_exp(base + 30, 16'h0000, 1'b0, 1'b0, "done_clr");
        push_exp(base + 33, 16'h0000, 1'b0, 1'b0, "idle_down_zero_no_start");
        push_exp(base + 35, 16'h0000, 1'b1, 1'b0, "idle_after_clr_starts");
        for (int c = 1; c <= 36; c++) begin
            case (c)
                1:  btn_clr = 1'b1;
                2:  begin btn_clr = 1'b0; load = 1'b1; dir = 1'b1; pre_dem = 4'd0; pre_unm = 4'd0; pre_des = 4'd0; pre_uns = 4'd2; end
                3:  begin load = 1'b0; btn_ss = 1'b1; end
                4:  btn_ss = 1'b0;
                26: btn_ss = 1'b1;
                27: btn_ss = 1'b0;
                30: btn_clr = 1'b1;
                31: btn_clr = 1'b0;
                32: btn_ss = 1'b1;
                33: btn_ss = 1'b0;
                35: begin dir = 1'b0; btn_ss = 1'b1; end
                36: btn_ss = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
        n_tests++;
        if (fin_cnt - fin0 !== 1) begin
            n_fail++;
            $display("FAIL down_fin_width: got %0d fin cycles want 1", fin_cnt - fin0);
        end
    endtask

    task automatic test_pause();
        int base = cyc;
        // RUN entered at edge 2; prescaler reaches 7 after edge 9 and is held
        // by the pause at edge 10, so after resume at edge 60 the step lands at 63.
        push_exp(base + 9,  16'h0000, 1'b1, 1'b0, "pause_running");
        push_exp(base + 10, 16'h0000, 1'b0, 1'b0, "pause_entered");
        push_exp(base + 35, 16'h0000, 1'b0, 1'b0, "pause_frozen_mid");
        push_exp(base + 59, 16'h0000, 1'b0, 1'b0, "pause_frozen_end");
        push_exp(base + 60, 16'h0000, 1'b1, 1'b0, "resume_fg");
        push_exp(base + 62, 16'h0000, 1'b1, 1'b0, "resume_before_step");
        push_exp(base + 63, 16'h0001, 1'b1, 1'b0, "resume_step_plus3");
        for (int c = 1; c <= 63; c++) begin
            case (c)
                1:  begin btn_clr = 1'b1; dir = 1'b0; end
                2:  begin btn_clr = 1'b0; btn_ss = 1'b1; end
                3:  btn_ss = 1'b0;
                10: btn_ss = 1'b1;
                11: btn_ss = 1'b0;
                60: btn_ss = 1'b1;
                61: btn_ss = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
    endtask

    task automatic test_load_rules();
        int base = cyc;
        push_exp(base + 2,  16'h5931, 1'b0, 1'b0, "load_saturate");
        push_exp(base + 4,  16'h5931, 1'b1, 1'b0, "load_run");
        push_exp(base + 9,  16'h5931, 1'b1, 1'b0, "load_in_run_ignored");
        push_exp(base + 13, 16'h5931, 1'b1, 1'b0, "load_run_before_tick");
        push_exp(base + 14, 16'h5932, 1'b1, 1'b0, "load_run_count_kept");
        for (int c = 1; c <= 14; c++) begin
            case (c)
                1:  btn_clr = 1'b1;
                2:  begin btn_clr = 1'b0; load = 1'b1; pre_dem = 4'd7; pre_unm = 4'd12; pre_des = 4'd3; pre_uns = 4'd1; end
                3:  load = 1'b0;
                4:  btn_ss = 1'b1;
                5:  btn_ss = 1'b0;
                8:  begin load = 1'b1; pre_dem = 4'd0; pre_unm = 4'd0; pre_des = 4'd0; pre_uns = 4'd0; end
                10: load = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
    endtask

    task automatic test_collisions();
        int base = cyc;
        push_exp(base + 1,  16'h0000, 1'b0, 1'b0, "clr_with_edge");
        push_exp(base + 3,  16'h0000, 1'b0, 1'b0, "clr_edge_consumed");
        push_exp(base + 15, 16'h0001, 1'b1, 1'b0, "restart_step");
        push_exp(base + 17, 16'h0000, 1'b0, 1'b0, "rst_mid_run");
        push_exp(base + 20, 16'h0000, 1'b0, 1'b0, "held_btn_no_start");
        push_exp(base + 22, 16'h0000, 1'b0, 1'b0, "held_btn_still_idle");
        for (int c = 1; c <= 23; c++) begin
            case (c)
                1:  begin btn_clr = 1'b1; btn_ss = 1'b1; end
                2:  btn_clr = 1'b0;
                4:  btn_ss = 1'b0;
                5:  btn_ss = 1'b1;
                6:  btn_ss = 1'b0;
                17: begin rst = 1'b1; btn_ss = 1'b1; end
                19: rst = 1'b0;
                23: btn_ss = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front(); n_tests++;
                if ({dem, unm, des, uns, fg, fin} !== {e.d, e.fg, e.fin}) begin
                    n_fail++;
                    $display("FAIL %s: got %h fg=%b fin=%b want %h fg=%b fin=%b", e.nm, {dem, unm, des, uns}, fg, fin, e.d, e.fg, e.fin);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrap();
        test_countdown();
        test_pause();
        test_load_rules();
        test_collisions();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
